// File: rtl/keypad_scan_debounce.sv
// 4x4 active-low matrix keypad scanner with tick-based press/release debounce.
// Emits one registered key code plus a single-cycle ready strobe per accepted press.
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_inrow,
  output logic [3:0] o_outcol,
  output logic [4:0] o_key_value,
  output logic       o_key_ready,
  output logic       o_key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // A sample is a hit only when exactly one row is pulled low.
  function automatic logic f_single_low(input logic [3:0] v);
    logic [2:0] zeros;
    zeros = 3'd0;
    for (int i = 0; i < 4; i++) begin
      zeros = zeros + {2'b00, ~v[i]};
    end
    return (zeros == 3'd1);
  endfunction

  function automatic logic [1:0] f_low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [DIV_W-1:0] r_div;
  state_t           r_state;
  logic [1:0]       r_col;
  logic [1:0]       r_row;
  logic [3:0]       r_pat;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rel;
  logic [3:0]       r_outcol;
  logic [4:0]       r_key_value;
  logic             r_key_ready;
  logic             r_key_down;

  logic             w_tick;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_rel_inc;
  state_t           w_state_nxt;
  logic [1:0]       w_col_nxt;
  logic [1:0]       w_row_nxt;
  logic [3:0]       w_pat_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_rel_nxt;
  logic [4:0]       w_value_nxt;
  logic             w_ready_nxt;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_hit     = f_single_low(r_sync2);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  assign w_rel_inc = (r_rel == CNT_MAX) ? r_rel : r_rel + CNT_ONE;

  // Row synchronizer and scan-tick divider.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_div   <= '0;
    end else begin
      r_sync1 <= i_inrow;
      r_sync2 <= r_sync1;
      r_div   <= w_tick ? '0 : r_div + DIV_W'(1'b1);
    end
  end

  // Scan/debounce/held next-state and output decisions, evaluated only on ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    w_rel_nxt   = r_rel;
    w_value_nxt = r_key_value;
    w_ready_nxt = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (w_hit) begin
            w_row_nxt = f_low_index(r_sync2);
            w_pat_nxt = r_sync2;
            if (CNT_TGT == CNT_ONE) begin
              w_value_nxt = {1'b0, f_low_index(r_sync2), r_col};
              w_ready_nxt = 1'b1;
              w_state_nxt = ST_HELD;
              w_cnt_nxt   = '0;
              w_rel_nxt   = '0;
            end else begin
              w_cnt_nxt   = CNT_ONE;
              w_state_nxt = ST_DEBOUNCE;
            end
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (r_sync2 == r_pat) begin
            if (w_cnt_inc >= CNT_TGT) begin
              w_value_nxt = {1'b0, r_row, r_col};
              w_ready_nxt = 1'b1;
              w_state_nxt = ST_HELD;
              w_cnt_nxt   = '0;
              w_rel_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            // Reject the attempt but stay on this column for a fresh look.
            w_state_nxt = ST_SCAN;
            w_cnt_nxt   = '0;
          end
        end
        ST_HELD: begin
          if (r_sync2 == 4'hF) begin
            if (w_rel_inc >= CNT_TGT) begin
              w_state_nxt = ST_SCAN;
              w_rel_nxt   = '0;
              w_col_nxt   = r_col + 2'd1;
            end else begin
              w_rel_nxt = w_rel_inc;
            end
          end else begin
            w_rel_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = ST_SCAN;
          w_cnt_nxt   = '0;
          w_rel_nxt   = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ST_SCAN;
      r_col       <= 2'd0;
      r_row       <= 2'd0;
      r_pat       <= 4'hF;
      r_cnt       <= '0;
      r_rel       <= '0;
      r_outcol    <= 4'b1110;
      r_key_value <= 5'd16;
      r_key_ready <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_pat       <= w_pat_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rel       <= w_rel_nxt;
      r_outcol    <= ~(4'b0001 << w_col_nxt);
      r_key_value <= w_value_nxt;
      r_key_ready <= w_ready_nxt;
      r_key_down  <= (w_state_nxt == ST_HELD);
    end
  end

  assign o_outcol    = r_outcol;
  assign o_key_value = r_key_value;
  assign o_key_ready = r_key_ready;
  assign o_key_down  = r_key_down;

endmodule
